gpr_writeback_queue: RTL and testbench

GPR_WRITEBACK_QUEUE -- requirements
Module: gpr_writeback_queue

---
 rtl/gpr_writeback_queue_if.sv | 40 ++++
 rtl/gpr_writeback_queue.sv | 131 +++++++++++++
 tb/tb_gpr_writeback_queue.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/gpr_writeback_queue_if.sv
// Bundle of the ALU/LSU result inputs, the registered GPR write port and
// the forwarding lookup used by gpr_writeback_queue.
interface gpr_writeback_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          aluValid;
    logic [4:0]    aluRegister;
    logic [31:0]   aluData;
    logic          lsuValid;
    logic [4:0]    lsuRegister;
    logic [31:0]   lsuData;
    logic          lsuReady;
    logic          gprWriteEnabled;
    logic [4:0]    gprWriteRegister;
    logic [31:0]   gprWriteInput;
    logic [4:0]    queryRegister;
    logic          queryPending;
    logic [31:0]   queryData;
    logic [CW-1:0] count;

    // Producer side: drives results and lookups, observes the write port
    modport master (
        output aluValid, aluRegister, aluData,
        output lsuValid, lsuRegister, lsuData,
        output queryRegister,
        input  lsuReady, gprWriteEnabled, gprWriteRegister, gprWriteInput,
        input  queryPending, queryData, count
    );

    // Queue side: consumes results, drives the GPR write port
    modport slave (
        input  aluValid, aluRegister, aluData,
        input  lsuValid, lsuRegister, lsuData,
        input  queryRegister,
        output lsuReady, gprWriteEnabled, gprWriteRegister, gprWriteInput,
        output queryPending, queryData, count
    );
endinterface

// File: rtl/gpr_writeback_queue.sv
// Writeback arbiter for a single GPR write port. ALU results are written
// the cycle after they arrive and always win; long-latency LSU results wait
// in a small FIFO and drain in order when the ALU is idle. An ALU write to a
// register kills older queued LSU writes to the same register, so a stale
// load can never overwrite a newer ALU value. A forwarding lookup reports
// the youngest pending value for any register.
module gpr_writeback_queue #(
    parameter int DEPTH = 4
) (
    input logic                   clock,
    input logic                   reset,
    gpr_writeback_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_killed;
    logic [4:0]       r_reg  [DEPTH];
    logic [31:0]      r_data [DEPTH];

    logic             r_outEn;
    logic [4:0]       r_outReg;
    logic [31:0]      r_outData;

    logic             w_lsuReady;
    logic             w_aluAccept;
    logic             w_lsuEnq;
    logic             w_drain;
    logic             w_qPending;
    logic [31:0]      w_qData;
    logic [PW-1:0]    w_idx;

    assign w_lsuReady  = reset && (r_count < CW'(DEPTH));
    assign w_aluAccept = bus.aluValid && (bus.aluRegister != 5'd0);
    assign w_lsuEnq    = bus.lsuValid && w_lsuReady && (bus.lsuRegister != 5'd0);
    assign w_drain     = !w_aluAccept && (r_count != '0);

    // Queue bookkeeping: pointers, occupancy and the live/killed bits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            r_killed <= '0;
        end else begin
            if (w_aluAccept) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_valid[i] && (r_reg[i] == bus.aluRegister)) begin
                        r_killed[i] <= 1'b1;
                    end
                end
            end
            if (w_drain) begin
                r_valid[r_head]  <= 1'b0;
                r_killed[r_head] <= 1'b0;
                r_head           <= r_head + 1'b1;
            end
            if (w_lsuEnq) begin
                r_valid[r_tail]  <= 1'b1;
                r_killed[r_tail] <= 1'b0;
                r_tail           <= r_tail + 1'b1;
            end
            case ({w_lsuEnq, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set
    always_ff @(posedge clock) begin
        if (w_lsuEnq) begin
            r_reg[r_tail]  <= bus.lsuRegister;
            r_data[r_tail] <= bus.lsuData;
        end
    end

    // Output stage: ALU result first, otherwise the queue head
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_outEn   <= 1'b0;
            r_outReg  <= '0;
            r_outData <= '0;
        end else if (w_aluAccept) begin
            r_outEn   <= 1'b1;
            r_outReg  <= bus.aluRegister;
            r_outData <= bus.aluData;
        end else if (w_drain && !r_killed[r_head]) begin
            r_outEn   <= 1'b1;
            r_outReg  <= r_reg[r_head];
            r_outData <= r_data[r_head];
        end else begin
            r_outEn   <= 1'b0;
        end
    end

    // Forwarding lookup: scan oldest to youngest so the newest live entry wins
    always_comb begin
        w_qPending = 1'b0;
        w_qData    = '0;
        w_idx      = '0;
        if (bus.queryRegister != 5'd0) begin
            if (r_outEn && (r_outReg == bus.queryRegister)) begin
                w_qPending = 1'b1;
                w_qData    = r_outData;
            end
            for (int k = 0; k < DEPTH; k++) begin
                w_idx = r_head + PW'(k);
                if (r_valid[w_idx] && !r_killed[w_idx] &&
                    (r_reg[w_idx] == bus.queryRegister)) begin
                    w_qPending = 1'b1;
                    w_qData    = r_data[w_idx];
                end
            end
        end
    end

    assign bus.lsuReady         = w_lsuReady;
    assign bus.gprWriteEnabled  = r_outEn;
    assign bus.gprWriteRegister = r_outReg;
    assign bus.gprWriteInput    = r_outData;
    assign bus.queryPending     = w_qPending;
    assign bus.queryData        = w_qData;
    assign bus.count            = r_count;
endmodule

// File: tb/tb_gpr_writeback_queue.sv
// Directed bench for gpr_writeback_queue with hand-computed expectations.
module tb_gpr_writeback_queue;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    gpr_writeback_queue_if #(.DEPTH(4)) bus ();

    gpr_writeback_queue #(.DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running 10-unit clock
    always #5 clock = ~clock;

    // Drive one cycle's worth of inputs
    task automatic applyStimulus(input logic aluV, input logic [4:0] aluR, input logic [31:0] aluD,
                                 input logic lsuV, input logic [4:0] lsuR, input logic [31:0] lsuD);
        bus.aluValid    = aluV;
        bus.aluRegister = aluR;
        bus.aluData     = aluD;
        bus.lsuValid    = lsuV;
        bus.lsuRegister = lsuR;
        bus.lsuData     = lsuD;
    endtask

    // Advance past the next rising edge and let outputs settle
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One counted comparison
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Check the write port in one call
    task automatic checkWrite(input string tag, input logic en, input logic [4:0] r, input logic [31:0] d);
        checkOutput({tag, ".en"}, 32'(bus.gprWriteEnabled), 32'(en));
        checkOutput({tag, ".reg"}, 32'(bus.gprWriteRegister), 32'(r));
        checkOutput({tag, ".data"}, bus.gprWriteInput, d);
    endtask

    initial begin
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.queryRegister = 5'd0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        checkWrite("reset", 1'b0, 5'd0, 32'h0);
        checkOutput("reset.count", 32'(bus.count), 32'd0);
        checkOutput("reset.lsuReady", 32'(bus.lsuReady), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("release.lsuReady", 32'(bus.lsuReady), 32'd1);

        // Single ALU write
        applyStimulus(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkWrite("alu5", 1'b1, 5'd5, 32'h11);
        tick();
        checkWrite("alu5.idle", 1'b0, 5'd5, 32'h11);

        // LSU streaming with the ALU idle: drains right behind the enqueue
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'hA1);
        tick();
        checkOutput("stream.count1", 32'(bus.count), 32'd1);
        checkOutput("stream.en0", 32'(bus.gprWriteEnabled), 32'd0);
        bus.queryRegister = 5'd1;
        #1;
        checkOutput("stream.qPend", 32'(bus.queryPending), 32'd1);
        checkOutput("stream.qData", bus.queryData, 32'hA1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'hA2);
        tick();
        checkWrite("stream.w1", 1'b1, 5'd1, 32'hA1);
        checkOutput("stream.count2", 32'(bus.count), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkWrite("stream.w2", 1'b1, 5'd2, 32'hA2);
        checkOutput("stream.count3", 32'(bus.count), 32'd0);
        tick();
        checkOutput("stream.done", 32'(bus.gprWriteEnabled), 32'd0);

        // Fill to DEPTH while the ALU holds the port, then drain in order
        applyStimulus(1'b1, 5'd20, 32'h20, 1'b1, 5'd1, 32'hB1);
        tick();
        applyStimulus(1'b1, 5'd20, 32'h20, 1'b1, 5'd2, 32'hB2);
        tick();
        applyStimulus(1'b1, 5'd20, 32'h20, 1'b1, 5'd3, 32'hB3);
        tick();
        applyStimulus(1'b1, 5'd20, 32'h20, 1'b1, 5'd4, 32'hB4);
        tick();
        checkOutput("full.count", 32'(bus.count), 32'd4);
        checkOutput("full.lsuReady", 32'(bus.lsuReady), 32'd0);
        checkWrite("full.alu", 1'b1, 5'd20, 32'h20);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hB5);
        tick();
        checkWrite("full.w1", 1'b1, 5'd1, 32'hB1);
        checkOutput("full.count3", 32'(bus.count), 32'd3);
        checkOutput("full.ready", 32'(bus.lsuReady), 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkWrite("full.w2", 1'b1, 5'd2, 32'hB2);
        checkOutput("full.countR5", 32'(bus.count), 32'd3);
        tick();
        checkWrite("full.w3", 1'b1, 5'd3, 32'hB3);
        tick();
        checkWrite("full.w4", 1'b1, 5'd4, 32'hB4);
        tick();
        checkWrite("full.w5", 1'b1, 5'd5, 32'hB5);
        checkOutput("full.empty", 32'(bus.count), 32'd0);
        tick();
        checkOutput("full.idle", 32'(bus.gprWriteEnabled), 32'd0);

        // ALU write kills an older queued LSU write to the same register
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hA);
        tick();
        applyStimulus(1'b1, 5'd7, 32'hB, 1'b0, 5'd0, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkWrite("kill.alu", 1'b1, 5'd7, 32'hB);
        checkOutput("kill.count", 32'(bus.count), 32'd1);
        bus.queryRegister = 5'd7;
        #1;
        checkOutput("kill.qPend", 32'(bus.queryPending), 32'd1);
        checkOutput("kill.qData", bus.queryData, 32'hB);
        tick();
        checkWrite("kill.drain", 1'b0, 5'd7, 32'hB);
        checkOutput("kill.empty", 32'(bus.count), 32'd0);

        // Same-edge ALU and LSU to R3: LSU is younger and stays live
        applyStimulus(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.queryRegister = 5'd3;
        #1;
        checkWrite("same.alu", 1'b1, 5'd3, 32'h1);
        checkOutput("same.qPend", 32'(bus.queryPending), 32'd1);
        checkOutput("same.qData", bus.queryData, 32'h2);
        tick();
        checkWrite("same.lsu", 1'b1, 5'd3, 32'h2);
        tick();
        checkOutput("same.idle", 32'(bus.gprWriteEnabled), 32'd0);
        bus.queryRegister = 5'd30;
        #1;
        checkOutput("nomatch.qPend", 32'(bus.queryPending), 32'd0);
        checkOutput("nomatch.qData", bus.queryData, 32'h0);

        // Register 0 is dropped from both sources
        applyStimulus(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("r0.en", 32'(bus.gprWriteEnabled), 32'd0);
        checkOutput("r0.count", 32'(bus.count), 32'd0);

        // Continuous ALU blocks the drain
        applyStimulus(1'b1, 5'd9, 32'h9, 1'b1, 5'd8, 32'h8);
        tick();
        applyStimulus(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'h10);
        tick();
        applyStimulus(1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 32'h0);
        tick();
        tick();
        checkOutput("block.count", 32'(bus.count), 32'd2);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkWrite("block.w1", 1'b1, 5'd8, 32'h8);
        tick();
        checkWrite("block.w2", 1'b1, 5'd10, 32'h10);
        checkOutput("block.empty", 32'(bus.count), 32'd0);

        // Reset mid-operation with three entries queued
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 5'd11, 32'hC1);
        tick();
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 5'd12, 32'hC2);
        tick();
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 5'd13, 32'hC3);
        tick();
        checkOutput("mid.count", 32'(bus.count), 32'd3);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        reset = 1'b0;
        #1;
        checkWrite("mid.reset", 1'b0, 5'd0, 32'h0);
        checkOutput("mid.count0", 32'(bus.count), 32'd0);
        checkOutput("mid.ready0", 32'(bus.lsuReady), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        checkOutput("mid.ready1", 32'(bus.lsuReady), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("mid.noStale", 32'(bus.gprWriteEnabled), 32'd0);
        end
        checkOutput("mid.countEnd", 32'(bus.count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
